// File: rtl/pc_gen_pkg.sv
// Shared constants, state encoding and small helpers for the fetch PC generator.
// Optional feature macro used across the slice: PC_MISALIGN_TRAP_EN.
package pc_gen_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0004;

  // Stall polarity shared with the stall controller.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: stall/ready in, redirect channels in, PC request out.
// Misalign reporting signals exist only when PC_MISALIGN_TRAP_EN is defined.
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NUM_REDIR = 2
);

  logic                      stall_i;
  logic                      fetch_ready_i;
  logic [NUM_REDIR-1:0]      redir_valid_i;
  logic [NUM_REDIR*XLEN-1:0] redir_target_i;
  logic [XLEN-1:0]           pc_o;
  logic                      pc_valid_o;
  logic                      flush_o;
  logic                      pend_o;
`ifdef PC_MISALIGN_TRAP_EN
  logic                      misalign_o;
  logic [XLEN-1:0]           misalign_addr_o;
`endif

  // master: stall controller / redirect sources / fetch unit side
  modport master (
    output stall_i, fetch_ready_i, redir_valid_i, redir_target_i,
`ifdef PC_MISALIGN_TRAP_EN
    input  misalign_o, misalign_addr_o,
`endif
    input  pc_o, pc_valid_o, flush_o, pend_o
  );

  modport slave (
    input  stall_i, fetch_ready_i, redir_valid_i, redir_target_i,
`ifdef PC_MISALIGN_TRAP_EN
    output misalign_o, misalign_addr_o,
`endif
    output pc_o, pc_valid_o, flush_o, pend_o
  );

endinterface

// File: rtl/pc_gen_redir_arb.sv
// Fixed-priority redirect arbiter: highest channel index wins; emits raw and
// instruction-aligned target of the winner.
module pc_gen_redir_arb
  import pc_gen_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int NUM_REDIR  = 2,
  parameter int INST_BYTES = 4,
  localparam int WIN_W     = idx_width(NUM_REDIR)
) (
  input  logic [NUM_REDIR-1:0]      i_valid,
  input  logic [NUM_REDIR*XLEN-1:0] i_target,
  output logic                      o_any,
  output logic [WIN_W-1:0]          o_win,
  output logic [XLEN-1:0]           o_target_raw,
  output logic [XLEN-1:0]           o_target_aligned
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

  logic [XLEN-1:0]  w_tgt [NUM_REDIR];
  logic [WIN_W-1:0] w_win;

  generate
    for (genvar gi = 0; gi < NUM_REDIR; gi++) begin : g_unpack
      assign w_tgt[gi] = i_target[gi*XLEN +: XLEN];
    end
  endgenerate

  // Ascending scan: the last valid channel seen is the highest-priority one.
  always_comb begin
    w_win = '0;
    for (int k = 0; k < NUM_REDIR; k++) begin
      if (i_valid[k]) w_win = WIN_W'(k);
    end
  end

  assign o_any            = |i_valid;
  assign o_win            = w_win;
  assign o_target_raw     = w_tgt[w_win];
  assign o_target_aligned = w_tgt[w_win] & ~ALIGN_MASK;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: sequential advance, prioritised redirects, one buffered
// redirect while stalled. Optional misaligned-target trap under PC_MISALIGN_TRAP_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter int              NUM_REDIR  = 2,
  parameter int              INST_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEF)
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(TRAP_VEC_DEF)
`endif
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.slave   bus
);

  localparam int              WIN_W      = idx_width(NUM_REDIR);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

  pc_state_e        r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_valid;
  logic             r_flush;
  logic [XLEN-1:0]  r_pend_tgt;
  logic [WIN_W-1:0] r_pend_idx;
`ifdef PC_MISALIGN_TRAP_EN
  logic             r_misalign;
  logic [XLEN-1:0]  r_misalign_addr;
`endif

  logic             w_any;
  logic [WIN_W-1:0] w_win;
  logic [XLEN-1:0]  w_arb_raw;
  logic [XLEN-1:0]  w_arb_aligned;
  logic             w_stalled;
  logic             w_adv;
  logic             w_new_wins;
  logic             w_use_pend;
  logic             w_load;
  logic             w_latch;
  logic [XLEN-1:0]  w_ld_aligned;
  logic [XLEN-1:0]  w_ld_pc;
`ifdef PC_MISALIGN_TRAP_EN
  logic [XLEN-1:0]  w_ld_raw;
  logic             w_ld_mis;
`endif

  pc_gen_redir_arb #(
    .XLEN       (XLEN),
    .NUM_REDIR  (NUM_REDIR),
    .INST_BYTES (INST_BYTES)
  ) u_arb (
    .i_valid          (bus.redir_valid_i),
    .i_target         (bus.redir_target_i),
    .o_any            (w_any),
    .o_win            (w_win),
    .o_target_raw     (w_arb_raw),
    .o_target_aligned (w_arb_aligned)
  );

  assign w_stalled  = (bus.stall_i == STOP);
  assign w_adv      = r_valid & bus.fetch_ready_i & ~w_stalled;
  // Ties go to the newer request so a re-issued redirect refreshes the buffer.
  assign w_new_wins = w_any & (w_win >= r_pend_idx);
  assign w_use_pend = (r_state == ST_HOLD) & ~w_new_wins;

  assign w_load  = ~w_stalled & ((r_state == ST_HOLD) | w_any);
  assign w_latch = w_stalled & ((r_state == ST_RUN) ? w_any : w_new_wins);

  assign w_ld_aligned = w_use_pend ? (r_pend_tgt & ~ALIGN_MASK) : w_arb_aligned;

`ifdef PC_MISALIGN_TRAP_EN
  assign w_ld_raw = w_use_pend ? r_pend_tgt : w_arb_raw;
  assign w_ld_mis = |(w_ld_raw & ALIGN_MASK);
  assign w_ld_pc  = w_ld_mis ? TRAP_VEC : w_ld_aligned;
`else
  assign w_ld_pc  = w_ld_aligned;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VEC;
      r_valid    <= 1'b0;
      r_flush    <= 1'b0;
      r_pend_tgt <= '0;
      r_pend_idx <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
`endif
    end else begin
      r_valid <= 1'b1;
      r_flush <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif

      if (w_load) begin
        r_pc    <= w_ld_pc;
        r_flush <= 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
        if (w_ld_mis) begin
          r_misalign      <= 1'b1;
          r_misalign_addr <= w_ld_raw;
        end
`endif
      end else if ((r_state == ST_RUN) && !w_any && w_adv) begin
        r_pc <= r_pc + XLEN'(INST_BYTES);
      end

      if (w_latch) begin
        r_pend_tgt <= w_arb_raw;
        r_pend_idx <= w_win;
      end

      case (r_state)
        ST_RUN:  if (w_any && w_stalled) r_state <= ST_HOLD;
        ST_HOLD: if (!w_stalled)         r_state <= ST_RUN;
        default:                         r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.pc_o       = r_pc;
  assign bus.pc_valid_o = r_valid;
  assign bus.flush_o    = r_flush;
  assign bus.pend_o     = (r_state == ST_HOLD);
`ifdef PC_MISALIGN_TRAP_EN
  assign bus.misalign_o      = r_misalign;
  assign bus.misalign_addr_o = r_misalign_addr;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic
// against a behavioural reference model; honours PC_MISALIGN_TRAP_EN.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int          XLEN    = 32;
  localparam int          NR      = 2;
  localparam int          IB      = 4;
  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam logic [31:0] WRAP_RV = 32'hFFFF_FFFC;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] TV      = 32'h0000_0004;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN), .NUM_REDIR(NR)) bus  ();
  pc_gen_if #(.XLEN(XLEN), .NUM_REDIR(NR)) wbus ();

  pc_gen #(.XLEN(XLEN), .NUM_REDIR(NR), .INST_BYTES(IB), .RESET_VEC(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  pc_gen #(.XLEN(XLEN), .NUM_REDIR(NR), .INST_BYTES(IB), .RESET_VEC(WRAP_RV)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc, m_pend_tgt, m_mis_addr;
  bit          m_valid, m_flush, m_pend, m_mis;
  int          m_pri;

  task automatic model_load(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    if (t % IB != 0) begin
      m_pc       = TV;
      m_mis      = 1'b1;
      m_mis_addr = t;
    end else begin
      m_pc = t;
    end
`else
    m_pc = t - (t % IB);
`endif
    m_flush = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit st, input bit rd, input logic [1:0] v,
                            input logic [31:0] t0, input logic [31:0] t1);
    logic [31:0] tg [2];
    int win;
    if (r) begin
      m_pc = RV; m_valid = 0; m_flush = 0; m_pend = 0;
      m_pend_tgt = 0; m_pri = 0; m_mis = 0; m_mis_addr = 0;
      return;
    end
    tg[0] = t0;
    tg[1] = t1;
    win = -1;
    for (int k = NR - 1; k >= 0; k--)
      if (v[k] && win < 0) win = k;
    m_flush = 0;
    m_mis   = 0;
    if (!m_pend) begin
      if (win >= 0 && !st) model_load(tg[win]);
      else if (win >= 0) begin
        m_pend = 1; m_pend_tgt = tg[win]; m_pri = win;
      end else if (m_valid && rd && !st) m_pc = m_pc + IB;
    end else if (st) begin
      if (win >= m_pri) begin
        m_pend_tgt = tg[win]; m_pri = win;
      end
    end else begin
      model_load((win >= m_pri) ? tg[win] : m_pend_tgt);
      m_pend = 0;
    end
    m_valid = 1;
  endtask

  task automatic cycle(input bit r, input bit st, input bit rd, input logic [1:0] v,
                       input logic [31:0] t0, input logic [31:0] t1,
                       input string tag, input bit verbose);
    rst                = r;
    bus.stall_i        = st;
    bus.fetch_ready_i  = rd;
    bus.redir_valid_i  = v;
    bus.redir_target_i = {t1, t0};
    model_step(r, st, rd, v, t0, t1);
    @(posedge clk);
    #1;
    check({tag, ".pc"},    bus.pc_o,       m_pc);
    check({tag, ".valid"}, bus.pc_valid_o, m_valid);
    check({tag, ".flush"}, bus.flush_o,    m_flush);
    check({tag, ".pend"},  bus.pend_o,     m_pend);
`ifdef PC_MISALIGN_TRAP_EN
    check({tag, ".mis"},   bus.misalign_o,      m_mis);
    check({tag, ".maddr"}, bus.misalign_addr_o, m_mis_addr);
`endif
    if (verbose)
      $display("[%0t] %s rst=%0b stall=%0b rdy=%0b v=%b t0=%h t1=%h -> pc=%h flush=%0b pend=%0b",
               $time, tag, r, st, rd, v, t0, t1, bus.pc_o, bus.flush_o, bus.pend_o);
  endtask

  initial begin
    logic [31:0] t0, t1;
    logic [1:0]  v;
    bit          r, st, rd;

    rst                 = 1'b1;
    wbus.stall_i        = NO_STOP;
    wbus.fetch_ready_i  = 1'b1;
    wbus.redir_valid_i  = '0;
    wbus.redir_target_i = '0;

    // Reset held two cycles
    cycle(1, 0, 1, 2'b00, 0, 0, "rst0", 1);
    check("rst0.pc_const", bus.pc_o, 32'h0);
    check("rst0.valid_const", bus.pc_valid_o, 1'b0);
    cycle(1, 0, 1, 2'b00, 0, 0, "rst1", 1);
    check("rst1.pc_const", bus.pc_o, 32'h0);
    check("wrap.rst_pc", wbus.pc_o, WRAP_RV);

    // Sequential fetch and wrap-around
    cycle(0, 0, 1, 2'b00, 0, 0, "seq0", 1);
    check("seq0.pc_const", bus.pc_o, 32'h0);
    check("seq0.valid_const", bus.pc_valid_o, 1'b1);
    check("wrap.first", wbus.pc_o, 32'hFFFF_FFFC);
    cycle(0, 0, 1, 2'b00, 0, 0, "seq1", 1);
    check("seq1.pc_const", bus.pc_o, 32'h4);
    check("wrap.second", wbus.pc_o, 32'h0);
    cycle(0, 0, 1, 2'b00, 0, 0, "seq2", 1);
    check("seq2.pc_const", bus.pc_o, 32'h8);
    cycle(0, 0, 1, 2'b00, 0, 0, "seq3", 1);
    cycle(0, 0, 1, 2'b00, 0, 0, "seq4", 1);
    check("seq4.pc_const", bus.pc_o, 32'h10);

    // Simultaneous redirects: ch1 wins
    cycle(0, 0, 1, 2'b11, 32'h100, 32'h200, "prio", 1);
    check("prio.pc_const", bus.pc_o, 32'h200);
    check("prio.flush_const", bus.flush_o, 1'b1);
    cycle(0, 0, 1, 2'b00, 0, 0, "prio_next", 1);
    check("prio_next.pc_const", bus.pc_o, 32'h204);
    check("prio_next.flush_const", bus.flush_o, 1'b0);

    // Buffered redirect while stalled; newer higher-priority replaces
    cycle(0, 1, 1, 2'b01, 32'h300, 0, "hold1", 1);
    cycle(0, 1, 1, 2'b10, 0, 32'h400, "hold2", 1);
    cycle(0, 1, 1, 2'b00, 0, 0, "hold3", 1);
    check("hold3.pend_const", bus.pend_o, 1'b1);
    check("hold3.pc_const", bus.pc_o, 32'h204);
    cycle(0, 0, 1, 2'b00, 0, 0, "release", 1);
    check("release.pc_const", bus.pc_o, 32'h400);
    check("release.flush_const", bus.flush_o, 1'b1);
    check("release.pend_const", bus.pend_o, 1'b0);

    // Lower-priority redirect discarded while holding
    cycle(0, 1, 1, 2'b10, 0, 32'h400, "lo1", 1);
    cycle(0, 1, 1, 2'b01, 32'h500, 0, "lo2", 1);
    cycle(0, 0, 1, 2'b00, 0, 0, "lo_rel", 1);
    check("lo_rel.pc_const", bus.pc_o, 32'h400);

    // Misaligned target
    cycle(0, 0, 1, 2'b01, 32'h102, 0, "mis", 1);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis.pc_const", bus.pc_o, 32'h4);
    check("mis.flag_const", bus.misalign_o, 1'b1);
    check("mis.addr_const", bus.misalign_addr_o, 32'h102);
    cycle(0, 0, 1, 2'b00, 0, 0, "mis_next", 1);
    check("mis_next.flag_const", bus.misalign_o, 1'b0);
    check("mis_next.addr_const", bus.misalign_addr_o, 32'h102);
`else
    check("mis.pc_const", bus.pc_o, 32'h100);
    cycle(0, 0, 1, 2'b00, 0, 0, "mis_next", 1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 75);
      v[0] = ($urandom_range(0, 99) < 25);
      v[1] = ($urandom_range(0, 99) < 25);
      t0 = $urandom;
      t1 = $urandom;
      if ($urandom_range(0, 1) == 1) t0[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) t1[1:0] = 2'b00;
      cycle(r, st, rd, v, t0, t1, "rnd", (v != 2'b00));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
